ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 103 ++++++++++
 tb/tb_ex_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flush, hold, bubble and advance actions, plus
// the multiply-accumulate loopback (hilo_temp/cnt) that returns to EX while
// EX is stalled on a multi-cycle operation.
module ex_mem_stage #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 8,
    parameter int CW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic            mem_stall,
    input  logic            ex_valid,
    input  logic [AW-1:0]   ex_wd,
    input  logic            ex_wreg,
    input  logic [DW-1:0]   ex_wdata,
    input  logic [OPW-1:0]  ex_aluop,
    input  logic [DW-1:0]   ex_mem_addr,
    input  logic [DW-1:0]   ex_reg2,
    input  logic            ex_whilo,
    input  logic [DW-1:0]   ex_hi,
    input  logic [DW-1:0]   ex_lo,
    input  logic [2*DW-1:0] hilo_temp_i,
    input  logic [CW-1:0]   cnt_i,
    output logic            mem_valid,
    output logic [AW-1:0]   mem_wd,
    output logic            mem_wreg,
    output logic [DW-1:0]   mem_wdata,
    output logic [OPW-1:0]  mem_aluop,
    output logic [DW-1:0]   mem_mem_addr,
    output logic [DW-1:0]   mem_reg2,
    output logic            mem_whilo,
    output logic [DW-1:0]   mem_hi,
    output logic [DW-1:0]   mem_lo,
    output logic [2*DW-1:0] hilo_temp_o,
    output logic [CW-1:0]   cnt_o
);

    // Stage register: flush beats hold, hold beats bubble, bubble beats advance.
    // A bubble keeps the accumulate loopback alive; an advance retires it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid    <= 1'b0;
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            hilo_temp_o  <= '0;
            cnt_o        <= '0;
        end else if (flush) begin
            mem_valid    <= 1'b0;
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            hilo_temp_o  <= '0;
            cnt_o        <= '0;
        end else if (mem_stall) begin
            // hold: every register keeps its value
            mem_valid    <= mem_valid;
        end else if (ex_stall) begin
            mem_valid    <= 1'b0;
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            hilo_temp_o  <= hilo_temp_i;
            cnt_o        <= cnt_i;
        end else begin
            // an empty EX slot is captured but can never write back
            mem_valid    <= ex_valid;
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg & ex_valid;
            mem_wdata    <= ex_wdata;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            mem_whilo    <= ex_whilo & ex_valid;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            hilo_temp_o  <= '0;
            cnt_o        <= '0;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed + randomized bench for ex_mem_stage with a behavioural model of
// the stage register's action rules.
module tb_ex_mem_stage;
    localparam int DW = 32, AW = 5, OPW = 8, CW = 2;

    logic            clk, rst, flush, ex_stall, mem_stall, ex_valid;
    logic [AW-1:0]   ex_wd;
    logic            ex_wreg, ex_whilo;
    logic [DW-1:0]   ex_wdata, ex_mem_addr, ex_reg2, ex_hi, ex_lo;
    logic [OPW-1:0]  ex_aluop;
    logic [2*DW-1:0] hilo_temp_i;
    logic [CW-1:0]   cnt_i;
    logic            mem_valid, mem_wreg, mem_whilo;
    logic [AW-1:0]   mem_wd;
    logic [DW-1:0]   mem_wdata, mem_mem_addr, mem_reg2, mem_hi, mem_lo;
    logic [OPW-1:0]  mem_aluop;
    logic [2*DW-1:0] hilo_temp_o;
    logic [CW-1:0]   cnt_o;

    ex_mem_stage #(.DW(DW), .AW(AW), .OPW(OPW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
    );

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   wd;
        logic            wreg;
        logic [DW-1:0]   wdata;
        logic [OPW-1:0]  aluop;
        logic [DW-1:0]   addr;
        logic [DW-1:0]   reg2;
        logic            whilo;
        logic [DW-1:0]   hi;
        logic [DW-1:0]   lo;
        logic [2*DW-1:0] hilo;
        logic [CW-1:0]   cnt;
    } st_t;

    st_t m;
    int  n_cmp = 0, n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t observe();
        st_t s;
        s = '{mem_valid, mem_wd, mem_wreg, mem_wdata, mem_aluop, mem_mem_addr,
              mem_reg2, mem_whilo, mem_hi, mem_lo, hilo_temp_o, cnt_o};
        return s;
    endfunction

    // Reference: what the stage should hold after an edge, stated as rules.
    task automatic model_edge();
        st_t nx;
        nx = m;
        if (!rst || flush) nx = '0;
        else if (mem_stall) nx = m;
        else if (ex_stall) begin
            nx      = '0;
            nx.hilo = hilo_temp_i;
            nx.cnt  = cnt_i;
        end else begin
            nx = '{ex_valid, ex_wd, ex_wreg && ex_valid, ex_wdata, ex_aluop, ex_mem_addr,
                   ex_reg2, ex_whilo && ex_valid, ex_hi, ex_lo, 64'd0, 2'd0};
        end
        m = nx;
    endtask

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chk_all(input string tag);
        st_t o;
        o = observe();
        n_cmp++;
        assert (o === m) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, o, m);
        end
    endtask

    // one edge: model follows the DUT, check just after the edge, return at negedge
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1 chk_all(tag);
        @(negedge clk);
    endtask

    task automatic set_ex(input logic v, input logic [AW-1:0] wd, input logic wr,
                          input logic [DW-1:0] wdata, input logic wh);
        ex_valid = v; ex_wd = wd; ex_wreg = wr; ex_wdata = wdata; ex_whilo = wh;
        ex_aluop = OPW'($urandom); ex_mem_addr = $urandom; ex_reg2 = $urandom;
        ex_hi = $urandom; ex_lo = $urandom;
    endtask

    task automatic rand_in();
        flush     = ($urandom_range(0, 15) == 0);
        mem_stall = ($urandom_range(0, 4) == 0);
        ex_stall  = ($urandom_range(0, 3) == 0);
        set_ex($urandom_range(0, 3) != 0, AW'($urandom), 1'($urandom), $urandom, 1'($urandom));
        hilo_temp_i = {$urandom, $urandom};
        cnt_i       = CW'($urandom);
    endtask

    initial begin
        rst = 1'b0; flush = 0; ex_stall = 0; mem_stall = 0;
        set_ex(0, '0, 0, '0, 0);
        hilo_temp_i = '0; cnt_i = '0;
        m = '0;
        #2 chk_all("reset_state");
        @(negedge clk);
        rst = 1'b1;

        // advance
        set_ex(1, 5'h03, 1, 32'hDEADBEEF, 0);
        tick("advance");
        chk("adv_wd", 64'(mem_wd), 64'h3);
        chk("adv_wreg", 64'(mem_wreg), 64'h1);
        chk("adv_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("adv_valid", 64'(mem_valid), 64'h1);
        chk("adv_cnt", 64'(cnt_o), 64'h0);

        // accumulate bubble then release
        ex_stall = 1; hilo_temp_i = 64'h1_0000_0002; cnt_i = 2'd1;
        tick("bubble");
        chk("bub_valid", 64'(mem_valid), 64'h0);
        chk("bub_wreg", 64'(mem_wreg), 64'h0);
        chk("bub_hilo", hilo_temp_o, 64'h1_0000_0002);
        chk("bub_cnt", 64'(cnt_o), 64'h1);
        ex_stall = 0;
        tick("bub_release");
        chk("rel_cnt", 64'(cnt_o), 64'h0);
        chk("rel_hilo", hilo_temp_o, 64'h0);

        // hold for 3 edges
        set_ex(1, 5'h07, 1, 32'h12345678, 0);
        tick("hold_load");
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = $urandom;
            tick("hold");
            chk("hold_wdata", 64'(mem_wdata), 64'h12345678);
            chk("hold_cnt", 64'(cnt_o), 64'h0);
        end
        mem_stall = 0;

        // accumulate state held by a MEM stall
        ex_stall = 1; hilo_temp_i = 64'hA5A5_0000_FFFF_0001; cnt_i = 2'd3;
        tick("acc_load");
        mem_stall = 1; hilo_temp_i = '0; cnt_i = 2'd0;
        tick("acc_hold");
        chk("acc_hold_cnt", 64'(cnt_o), 64'h3);

        // flush beats both stalls
        flush = 1;
        tick("flush_prio");
        chk("flush_cnt", 64'(cnt_o), 64'h0);
        chk("flush_hilo", hilo_temp_o, 64'h0);
        flush = 0; mem_stall = 0; ex_stall = 0;

        // async reset mid-accumulate discards loopback
        ex_stall = 1; hilo_temp_i = 64'h1234; cnt_i = 2'd2;
        tick("acc_pre_rst");
        #2 rst = 0;
        #1 m = '0;
        chk("rst_acc_cnt", 64'(cnt_o), 64'h0);
        chk("rst_acc_hilo", hilo_temp_o, 64'h0);
        @(negedge clk);
        rst = 1; ex_stall = 0;

        // async reset while wreg=1, held through 2 edges
        set_ex(1, 5'h1F, 1, 32'hCAFEF00D, 1);
        tick("pre_rst");
        chk("pre_rst_wreg", 64'(mem_wreg), 64'h1);
        #2 rst = 0;
        #1 m = '0;
        chk("async_wreg", 64'(mem_wreg), 64'h0);
        chk("async_cnt", 64'(cnt_o), 64'h0);
        @(negedge clk);
        tick("rst_hold1");
        tick("rst_hold2");
        rst = 1;
        tick("rst_release");
        chk("release_valid", 64'(mem_valid), 64'h1);

        // invalid slot
        set_ex(0, 5'h09, 1, 32'h55AA55AA, 1);
        tick("invalid");
        chk("inv_wreg", 64'(mem_wreg), 64'h0);
        chk("inv_whilo", 64'(mem_whilo), 64'h0);
        chk("inv_valid", 64'(mem_valid), 64'h0);
        chk("inv_wdata", 64'(mem_wdata), 64'h55AA55AA);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_in();
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
